// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock after a
// start/busy/done handshake. Divide-by-zero finishes immediately with a flag.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] shq_q, shq_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   step;

    // Returns {no_borrow, next partial remainder}. The trial subtract is
    // WIDTH+1 bits wide (A + ~B + 1), so its carry-out means T >= divisor.
    function automatic logic [WIDTH:0] restore_step(
        input logic [WIDTH-1:0] r,
        input logic             q_msb,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0]   t;
        logic [WIDTH+1:0] s;
        t = {r, q_msb};
        s = {1'b0, t} + {1'b0, ~{1'b0, d}} + {{(WIDTH + 1){1'b0}}, 1'b1};
        if (s[WIDTH+1]) begin
            return {1'b1, s[WIDTH-1:0]};
        end
        return {1'b0, t[WIDTH-1:0]};
    endfunction

    always_comb begin
        state_d = state_q;
        part_d  = part_q;
        shq_d   = shq_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        step    = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvsr_d = divisor;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        part_d  = '0;
                        shq_d   = dividend;
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                step   = restore_step(part_q, shq_q[WIDTH-1], dvsr_q);
                part_d = step[WIDTH-1:0];
                shq_d  = {shq_q[WIDTH-2:0], step[WIDTH]};
                cnt_d  = cnt_q - 1'b1;
                // Published results stay frozen during RUN; they update only here.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    quot_d  = {shq_q[WIDTH-2:0], step[WIDTH]};
                    rem_d   = step[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            part_q  <= '0;
            shq_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            part_q  <= part_d;
            shq_q   <= shq_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
